// File: rtl/keypad_scanner.sv
// keypad_scanner
// Clocked matrix-keypad scanner. Drives one row low at a time, samples the
// synchronised column lines after a settle interval, assembles a full-matrix
// frame, debounces whole frames and emits one-cycle key events.
//
// Ports:
//   CLK          system clock
//   RST          synchronous, active-high reset
//   ROW          row drives, active-low, one bit low while scanning
//   COL          column sense, active-low (board pull-ups)
//   KEY_STATE    debounced key state, bit r*NCOLS+c = 1 means pressed
//   KEY_VALID    one-cycle event strobe
//   KEY_CODE     key index of the event (valid with KEY_VALID)
//   KEY_PRESSED  1 = press event, 0 = release event (valid with KEY_VALID)
//
// Optional feature macro: KEYPAD_RELEASE_EVENT_EN
//   defined   : releases also queue events (KEY_PRESSED=0)
//   undefined : only presses queue events; KEY_STATE still tracks releases
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SETTLE_CYCLES   = 12000,
  parameter int DEBOUNCE_FRAMES = 4,
  localparam int NKEYS          = NROWS * NCOLS,
  localparam int CW             = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [NROWS-1:0] ROW,
  input  logic [NCOLS-1:0] COL,
  output logic [NKEYS-1:0] KEY_STATE,
  output logic             KEY_VALID,
  output logic [CW-1:0]    KEY_CODE,
  output logic             KEY_PRESSED
);

  localparam int RW  = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DFW = $clog2(DEBOUNCE_FRAMES + 1);

  // Saturating increment of the stable-frame count.
  function automatic logic [DFW-1:0] sat_inc(input logic [DFW-1:0] v);
    if (v >= DFW'(DEBOUNCE_FRAMES))
      return DFW'(DEBOUNCE_FRAMES);
    else
      return v + 1'b1;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [CW-1:0] lowest_index(input logic [NKEYS-1:0] m);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--)
      if (m[i]) idx = CW'(i);
    return idx;
  endfunction

  logic [NCOLS-1:0] col_p0;
  logic [NCOLS-1:0] col_p1;
  logic [NCOLS-1:0] pressed;
  logic [RW-1:0]    row_idx;
  logic [SCW-1:0]   settle_cnt;
  logic [NKEYS-1:0] frame;
  logic [NKEYS-1:0] candidate;
  logic [DFW-1:0]   stable_cnt;
  logic [NKEYS-1:0] pending;

  logic             sample_now;
  logic             frame_done;
  logic             accept;
  logic [NKEYS-1:0] frame_next;
  logic [NKEYS-1:0] changes;
  logic [NKEYS-1:0] lowest;

  assign pressed = ~col_p1;

  always_comb begin
    sample_now = (settle_cnt == SCW'(SETTLE_CYCLES - 1));
    frame_done = sample_now && (row_idx == RW'(NROWS - 1));

    // Frame value including the row sampled this cycle, so a completing
    // frame is judged with its last row already in place.
    frame_next = frame;
    for (int r = 0; r < NROWS; r++)
      if (sample_now && (row_idx == RW'(r)))
        frame_next[r*NCOLS +: NCOLS] = pressed;

    accept = (stable_cnt == DFW'(DEBOUNCE_FRAMES)) && (candidate != KEY_STATE);

`ifdef KEYPAD_RELEASE_EVENT_EN
    changes = KEY_STATE ^ candidate;
`else
    changes = ~KEY_STATE & candidate;
`endif

    // Isolate the lowest pending bit: two's-complement trick.
    lowest = pending & (~pending + 1'b1);

    KEY_VALID = |pending;
    KEY_CODE  = lowest_index(pending);
`ifdef KEYPAD_RELEASE_EVENT_EN
    KEY_PRESSED = |(lowest & KEY_STATE);
`else
    KEY_PRESSED = KEY_VALID;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_p0     <= '1;
      col_p1     <= '1;
      ROW        <= '1;
      row_idx    <= '0;
      settle_cnt <= '0;
      frame      <= '0;
      candidate  <= '0;
      stable_cnt <= '0;
      KEY_STATE  <= '0;
      pending    <= '0;
    end else begin
      // stage p0/p1: column synchroniser
      col_p0 <= COL;
      col_p1 <= col_p0;

      // row drive follows row_idx one cycle later
      ROW <= ~(NROWS'(1) << row_idx);

      // settle counter and row sampling
      if (sample_now) begin
        settle_cnt <= '0;
        frame      <= frame_next;
        if (row_idx == RW'(NROWS - 1))
          row_idx <= '0;
        else
          row_idx <= row_idx + 1'b1;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end

      // frame debounce
      if (frame_done) begin
        if (frame_next == candidate) begin
          stable_cnt <= sat_inc(stable_cnt);
        end else begin
          candidate  <= frame_next;
          stable_cnt <= DFW'(1);
        end
      end

      // acceptance and event queue
      if (accept)
        KEY_STATE <= candidate;
      pending <= (pending & ~lowest) | (accept ? changes : '0);
    end
  end

endmodule
